// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART TX sequencer.
//   tx_state_e   : FSM state codes (IDLE/LOAD/DATA/STOP)
//   DEF_BAUD_DIV : default clk cycles per bit (50 MHz / 9600)
//   clog2        : counter width helper, never returns less than 1
package uart_tx_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } tx_state_e;

  localparam int DEF_BAUD_DIV = 5208;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r == 0) r = 1;
    return r;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..DIV-1 and wraps.
//   clk, reset : clock / synchronous active-high reset
//   clr        : forces the count to 0 (used on FSM state entry)
//   tc         : terminal count, high while count == DIV-1
module uart_baud_cnt import uart_tx_ctrl_pkg::*; #(
  parameter int DIV = DEF_BAUD_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tc
);
  localparam int CW = clog2(DIV);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (tc)      cnt <= '0;
    else              cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer driving the TX shift register.
//   clk, reset   : clock / synchronous active-high reset
//   start,DataIn : send request (sampled only in IDLE) and the word to send
//   DataTX       : held word for the shift register's parallel load
//   load         : shift register parallel load of {DataTX,1'b0}
//   shift        : shift register advance, one per bit period
//   transmit_int : 1 = line follows shift register bit 0, 0 = line idles high
//   busy         : frame in progress
//   tx_done      : one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_ctrl import uart_tx_ctrl_pkg::*; #(
  parameter int WORD_LENGTH = 8,
  parameter int BAUD_DIV    = DEF_BAUD_DIV,
  parameter int STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] DataIn,
  output logic [WORD_LENGTH-1:0] DataTX,
  output logic                   load,
  output logic                   shift,
  output logic                   transmit_int,
  output logic                   busy,
  output logic                   tx_done
);
  localparam int BW = clog2(WORD_LENGTH + 1);
  // DATA covers the start bit plus WORD_LENGTH data bits, so the last
  // period index equals WORD_LENGTH.
  localparam logic [BW-1:0] DATA_LAST = BW'(WORD_LENGTH);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_e     state;
  logic [BW-1:0] bit_cnt;
  logic          baud_tc;
  logic          baud_clr;

  // Hold the period counter at 0 until DATA starts; it wraps to 0 by itself
  // on the DATA->STOP edge, so STOP also begins from a clean period.
  assign baud_clr = (state == IDLE) || (state == LOAD);

  uart_baud_cnt #(.DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (baud_clr),
    .tc    (baud_tc)
  );

  assign load         = (state == LOAD);
  assign transmit_int = (state == DATA);
  assign busy         = (state != IDLE);
  assign shift        = (state == DATA) && baud_tc;

  // bit_cnt counts bit periods in DATA and is reused to count stop
  // periods in STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      DataTX  <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            DataTX <= DataIn;
            state  <= LOAD;
          end
        end
        LOAD: begin
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (baud_tc) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        STOP: begin
          if (baud_tc) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
              tx_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
